// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage hazard unit with an in-flight destination scoreboard
module hazard_scoreboard #(
  parameter int REG_W    = 4,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic             id_wb_en,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_mem_r_en,
  input  logic             id_is_branch,
  input  logic             forward_en,
  input  logic             flush,
  input  logic             freeze,
  output logic             hazard_detected,
  output logic [DEPTH-1:0] inflight_mask,
  output logic [CNT_W-1:0] stall_count
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] wb_en_q, wb_en_d;
  logic [DEPTH-1:0] mem_r_en_q, mem_r_en_d;
  logic [REG_W-1:0] dest_q [DEPTH];
  logic [REG_W-1:0] dest_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DEPTH-1:0] match;
  logic             raw_hazard;
  logic             fwd_hazard;
  logic             issue;

  // Entries are compared before the shift, so a retiring producer still matches.
  always_comb begin
    raw_hazard = 1'b0;
    fwd_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] & wb_en_q[i] &
                 ((src1 == dest_q[i]) | (two_src & (src2 == dest_q[i])));
      raw_hazard = raw_hazard | match[i];
      fwd_hazard = fwd_hazard |
                   (match[i] & (id_is_branch | (mem_r_en_q[i] & (i < LOAD_LAT))));
    end
  end

  assign hazard_detected = id_valid & (forward_en ? fwd_hazard : raw_hazard);
  assign inflight_mask   = valid_q & wb_en_q;
  assign stall_count     = cnt_q;
  assign issue           = id_valid & ~hazard_detected & ~flush;

  always_comb begin
    valid_d    = valid_q;
    wb_en_d    = wb_en_q;
    mem_r_en_d = mem_r_en_q;
    for (int i = 0; i < DEPTH; i++) begin
      dest_d[i] = dest_q[i];
    end
    cnt_d = cnt_q;

    if (!freeze) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        valid_d[i]    = valid_q[i-1];
        wb_en_d[i]    = wb_en_q[i-1];
        mem_r_en_d[i] = mem_r_en_q[i-1];
        dest_d[i]     = dest_q[i-1];
      end
      valid_d[0]    = issue;
      wb_en_d[0]    = issue & id_wb_en;
      mem_r_en_d[0] = issue & id_mem_r_en;
      dest_d[0]     = issue ? id_dest : '0;

      if (hazard_detected && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      wb_en_q    <= '0;
      mem_r_en_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= dest_d[i];
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed-vector bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] src1, src2, id_dest;
  logic       two_src, id_wb_en, id_mem_r_en, id_is_branch;
  logic       forward_en, flush, freeze;

  logic        hz_a, hz_b, hz_c;
  logic [1:0]  mask_a, mask_c;
  logic [2:0]  mask_b;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  // a: defaults; b: deeper pipe with two-stage load latency; c: 2-bit counter
  hazard_scoreboard u_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .two_src(two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_mem_r_en(id_mem_r_en), .id_is_branch(id_is_branch),
    .forward_en(forward_en), .flush(flush), .freeze(freeze),
    .hazard_detected(hz_a), .inflight_mask(mask_a), .stall_count(cnt_a)
  );

  hazard_scoreboard #(.DEPTH(3), .LOAD_LAT(2)) u_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .two_src(two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_mem_r_en(id_mem_r_en), .id_is_branch(id_is_branch),
    .forward_en(forward_en), .flush(flush), .freeze(freeze),
    .hazard_detected(hz_b), .inflight_mask(mask_b), .stall_count(cnt_b)
  );

  hazard_scoreboard #(.CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .two_src(two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_mem_r_en(id_mem_r_en), .id_is_branch(id_is_branch),
    .forward_en(forward_en), .flush(flush), .freeze(freeze),
    .hazard_detected(hz_c), .inflight_mask(mask_c), .stall_count(cnt_c)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    id_valid = 0; src1 = 0; src2 = 0; two_src = 0; id_wb_en = 0;
    id_dest = 0; id_mem_r_en = 0; id_is_branch = 0; flush = 0; freeze = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic drive(input logic [3:0] s1, input logic [3:0] s2, input logic ts,
                       input logic wb, input logic [3:0] d, input logic ld,
                       input logic br);
    id_valid = 1; src1 = s1; src2 = s2; two_src = ts; id_wb_en = wb;
    id_dest = d; id_mem_r_en = ld; id_is_branch = br;
  endtask

  initial begin
    idle();
    forward_en = 0;
    rst = 0;
    do_reset();
    settle();
    chk("rst_hz", 32'(hz_a), 32'd0);
    chk("rst_mask", 32'(mask_a), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);

    // Non-forwarding: ADD R3 then consumer of R3 stalls DEPTH cycles
    drive(4'd0, 4'd0, 0, 1, 4'd3, 0, 0);
    settle(); chk("add_issue_hz", 32'(hz_a), 32'd0);
    tick();
    drive(4'd3, 4'd0, 0, 0, 4'd0, 0, 0);
    settle(); chk("nf_stall0", 32'(hz_a), 32'd1);
    chk("nf_mask0", 32'(mask_a), 32'd1);
    tick();
    settle(); chk("nf_stall1", 32'(hz_a), 32'd1);
    chk("nf_mask1", 32'(mask_a), 32'd2);
    tick();
    settle(); chk("nf_clear", 32'(hz_a), 32'd0);
    chk("nf_cnt", 32'(cnt_a), 32'd2);

    // Forwarding, ALU producer R5, consumer via src2
    forward_en = 1;
    do_reset();
    drive(4'd0, 4'd0, 0, 1, 4'd5, 0, 0);
    tick();
    drive(4'd0, 4'd5, 1, 1, 4'd6, 0, 0);
    settle(); chk("fw_alu_src2", 32'(hz_a), 32'd0);
    tick();
    settle(); chk("fw_alu_mask", 32'(mask_a), 32'd3);
    chk("fw_alu_cnt", 32'(cnt_a), 32'd0);
    do_reset();
    drive(4'd0, 4'd0, 0, 1, 4'd5, 0, 0);
    tick();
    drive(4'd0, 4'd5, 0, 1, 4'd6, 0, 0);
    settle(); chk("fw_alu_1src", 32'(hz_a), 32'd0);
    forward_en = 0;
    settle(); chk("nf_src2_unused", 32'(hz_a), 32'd0);
    forward_en = 1;

    // Load-use: 1 stall by default, 2 with LOAD_LAT=2
    do_reset();
    drive(4'd0, 4'd0, 0, 1, 4'd7, 1, 0);
    tick();
    drive(4'd7, 4'd0, 0, 0, 4'd0, 0, 0);
    settle(); chk("ld_a_c0", 32'(hz_a), 32'd1);
    chk("ld_b_c0", 32'(hz_b), 32'd1);
    tick();
    settle(); chk("ld_a_c1", 32'(hz_a), 32'd0);
    chk("ld_b_c1", 32'(hz_b), 32'd1);
    tick();
    settle(); chk("ld_b_c2", 32'(hz_b), 32'd0);
    chk("ld_a_cnt", 32'(cnt_a), 32'd1);
    chk("ld_b_cnt", 32'(cnt_b), 32'd2);

    // Branch in ID needs the value: stalls DEPTH cycles despite forwarding
    do_reset();
    drive(4'd0, 4'd0, 0, 1, 4'd2, 0, 0);
    tick();
    drive(4'd2, 4'd0, 0, 0, 4'd0, 0, 1);
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("br_a_c%0d", c), 32'(hz_a), (c < 2) ? 32'd1 : 32'd0);
      chk($sformatf("br_b_c%0d", c), 32'(hz_b), (c < 3) ? 32'd1 : 32'd0);
      tick();
    end
    chk("br_a_cnt", 32'(cnt_a), 32'd2);
    chk("br_b_cnt", 32'(cnt_b), 32'd3);

    // Freeze holds entries and counter while hazard stays visible
    forward_en = 0;
    do_reset();
    drive(4'd0, 4'd0, 0, 1, 4'd4, 0, 0);
    tick();
    drive(4'd4, 4'd0, 0, 0, 4'd0, 0, 0);
    freeze = 1;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk($sformatf("frz_hz%0d", c), 32'(hz_a), 32'd1);
      chk($sformatf("frz_mask%0d", c), 32'(mask_a), 32'd1);
      chk($sformatf("frz_cnt%0d", c), 32'(cnt_a), 32'd0);
      tick();
    end
    freeze = 0;
    settle(); chk("unfrz_hz0", 32'(hz_a), 32'd1);
    tick();
    settle(); chk("unfrz_hz1", 32'(hz_a), 32'd1);
    tick();
    settle(); chk("unfrz_hz2", 32'(hz_a), 32'd0);
    chk("unfrz_cnt", 32'(cnt_a), 32'd2);

    // Flush squashes issue but does not mask the hazard
    do_reset();
    drive(4'd0, 4'd0, 0, 1, 4'd9, 0, 0);
    flush = 1;
    tick();
    settle(); chk("flush_mask", 32'(mask_a), 32'd0);
    flush = 0;
    tick();
    drive(4'd9, 4'd0, 0, 0, 4'd0, 0, 0);
    flush = 1;
    settle(); chk("flush_hz", 32'(hz_a), 32'd1);
    flush = 0;

    // Self-dependent stream: 5 stall cycles in 8 edges, saturates 2-bit counter
    do_reset();
    drive(4'd1, 4'd0, 0, 1, 4'd1, 0, 0);
    for (int c = 0; c < 8; c++) tick();
    settle();
    chk("sat_a_cnt", 32'(cnt_a), 32'd5);
    chk("sat_c_cnt", 32'(cnt_c), 32'd3);
    chk("sat_c_mask", 32'(mask_c), 32'd2);

    // Reset wins over freeze with live entries
    rst = 1;
    freeze = 1;
    tick();
    settle();
    chk("rstfrz_mask_a", 32'(mask_a), 32'd0);
    chk("rstfrz_cnt_a", 32'(cnt_a), 32'd0);
    chk("rstfrz_mask_c", 32'(mask_c), 32'd0);
    chk("rstfrz_cnt_c", 32'(cnt_c), 32'd0);
    chk("rstfrz_hz", 32'(hz_a), 32'd0);
    rst = 0;
    freeze = 0;
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
